pipeline_stall_controller: RTL and testbench

//  Central sequencer for pipeline freeze/flush in the 5-stage ARM core. Merges the hazard

---
 rtl/pipeline_stall_controller.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/flush sequencer for the 5-stage core: merges memory wait, branch
// squash and data-hazard stalls, with a memory-wait watchdog and saturating perf counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_Detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_PC,
    output logic             freeze_IF_ID,
    output logic             freeze_ID_EXE,
    output logic             freeze_EXE_MEM,
    output logic             freeze_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EXE,
    output logic             mem_error,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             mem_error_reg, mem_error_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic             mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            mem_error_reg <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_error_reg <= mem_error_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Stage controls are combinational so the stall takes effect in the same cycle;
    // they are held low while reset is asserted.
    always_comb begin
        freeze_PC      = 1'b0;
        freeze_IF_ID   = 1'b0;
        freeze_ID_EXE  = 1'b0;
        freeze_EXE_MEM = 1'b0;
        freeze_MEM_WB  = 1'b0;
        flush_IF_ID    = 1'b0;
        flush_ID_EXE   = 1'b0;
        mem_stall      = ((state_reg == RUN) && mem_req && !mem_ready) ||
                         ((state_reg == MEM_WAIT) && !mem_ready) ||
                         (state_reg == ERR);
        if (rst) begin
            if (mem_stall) begin
                freeze_PC      = 1'b1;
                freeze_IF_ID   = 1'b1;
                freeze_ID_EXE  = 1'b1;
                freeze_EXE_MEM = 1'b1;
                freeze_MEM_WB  = 1'b1;
            end else if (branch_taken) begin
                flush_IF_ID  = 1'b1;
                flush_ID_EXE = 1'b1;
            end else if (hazard_Detected) begin
                freeze_PC    = 1'b1;
                freeze_IF_ID = 1'b1;
                flush_ID_EXE = 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_error_next = mem_error_reg;
        case (state_reg)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_reg == TIMEOUT_CNT)) begin
                    state_next     = ERR;
                    mem_error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_ONE;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Perf counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (freeze_PC && (stall_cnt_reg != CNT_MAX))
            stall_cnt_next = stall_cnt_reg + CNT_ONE;
        if (flush_IF_ID && (flush_cnt_reg != CNT_MAX))
            flush_cnt_next = flush_cnt_reg + CNT_ONE;
    end

    assign mem_error    = mem_error_reg;
    assign state_dbg    = state_reg;
    assign stall_cycles = stall_cnt_reg;
    assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a driver pushes expected responses
// from a behavioural model, a monitor pops and compares them mid-cycle.
module tb_pipeline_stall_controller;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hazard_Detected = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, freeze_MEM_WB;
    logic          flush_IF_ID, flush_ID_EXE, mem_error;
    logic [1:0]    state_dbg;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .hazard_Detected(hazard_Detected), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID), .freeze_ID_EXE(freeze_ID_EXE),
        .freeze_EXE_MEM(freeze_EXE_MEM), .freeze_MEM_WB(freeze_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EXE(flush_ID_EXE),
        .mem_error(mem_error), .state_dbg(state_dbg),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        logic [4:0] frz;
        logic [1:0] fls;
        logic       err;
        int         st;
        int         stall;
        int         flc;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int issued = 0;

    // Reference model: mode 0 running, 1 waiting on memory, 2 failed.
    int mode = 0, waited = 0, stalls = 0, flushes = 0;
    bit failed = 0;

    task automatic apply(input bit r, input bit h, input bit b, input bit q, input bit y);
        exp_t e;
        bit   blocked;
        @(posedge clk);
        #1;
        rst = r; hazard_Detected = h; branch_taken = b; mem_req = q; mem_ready = y;
        e.frz = '0; e.fls = '0; e.idx = issued;
        issued++;
        if (!r) begin
            mode = 0; waited = 0; failed = 0; stalls = 0; flushes = 0;
        end else begin
            blocked = (mode == 2) || (mode == 1 && !y) || (mode == 0 && q && !y);
            if (blocked)     e.frz = 5'b11111;
            else if (b)      e.fls = 2'b11;
            else if (h) begin
                e.frz = 5'b11000;
                e.fls = 2'b01;
            end
        end
        e.err = failed; e.st = mode; e.stall = stalls; e.flc = flushes;
        sb.push_back(e);
        if (r) begin
            if (e.frz[4]) stalls  = (stalls  + 1 > MAXC) ? MAXC : stalls + 1;
            if (e.fls[1]) flushes = (flushes + 1 > MAXC) ? MAXC : flushes + 1;
            if (mode == 0 && q && !y) begin
                mode = 1; waited = 1;
            end else if (mode == 1) begin
                if (y) begin
                    mode = 0; waited = 0;
                end else if (TO != 0 && waited == TO) begin
                    mode = 2; failed = 1;
                end else begin
                    waited = waited + 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input int idx, input int got, input int want);
        if (got != want) begin
            miscompares++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            check("freeze", e.idx,
                  int'({freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, freeze_MEM_WB}),
                  int'(e.frz));
            check("flush", e.idx, int'({flush_IF_ID, flush_ID_EXE}), int'(e.fls));
            check("mem_error", e.idx, int'(mem_error), int'(e.err));
            check("state_dbg", e.idx, int'(state_dbg), e.st);
            check("stall_cycles", e.idx, int'(stall_cycles), e.stall);
            check("flush_count", e.idx, int'(flush_count), e.flc);
            $display("vec %0d rst=%0b hz=%0b br=%0b req=%0b rdy=%0b frz=%05b fls=%02b st=%0d stall=%0d flc=%0d",
                     e.idx, rst, hazard_Detected, branch_taken, mem_req, mem_ready,
                     {freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM, freeze_MEM_WB},
                     {flush_IF_ID, flush_ID_EXE}, state_dbg, stall_cycles, flush_count);
        end
    end

    initial begin
        int pct;
        repeat (3) apply(0, 1, 1, 1, 0);
        repeat (10) apply(1, 0, 0, 0, 0);
        repeat (3) apply(1, 1, 0, 0, 0);
        apply(1, 1, 1, 0, 0);
        repeat (3) apply(1, 0, 1, 1, 0);
        apply(1, 0, 1, 1, 1);
        apply(1, 0, 0, 1, 1);
        apply(1, 0, 0, 0, 0);
        repeat (8) apply(1, 0, 0, 1, 0);
        apply(1, 1, 1, 1, 1);
        apply(0, 1, 1, 1, 0);
        repeat (2) apply(1, 0, 0, 0, 0);
        repeat (20) apply(1, 1, 0, 0, 0);
        repeat (3) apply(1, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0);
        for (int blk = 0; blk < 8; blk++) begin
            pct = $urandom_range(10, 90);
            for (int i = 0; i < 50; i++) begin
                apply($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 99) < pct);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
